pc_sequencer: RTL and testbench

Parametrised next-generation program-counter unit for the multi-cycle core. It selects among four next-PC sources: sequential, branch, jump and return. It adds a hardware return-address stack (RAS), so CALL pushes and RET pops internally instead of relying on an external stack bus. It also adds a stall enable, a programmable reset vector, and sticky stack-fault flags. It sits between the control unit (pc_src, call, pc_en) and the instruction-memory address port.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/ras_stack.sv | 64 ++++++
 rtl/pc_sequencer.sv | 59 +++++
 tb/tb_pc_sequencer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC source encodings and return-address-stack occupancy states.
//   pc_src_e    : 2-bit next-PC select used by the control unit and pc_sequencer
//   ras_state_e : occupancy of the return-address stack
package pc_pkg;
  typedef enum logic [1:0] {
    PC_SRC_DFT = 2'd0,
    PC_SRC_BTA = 2'd1,
    PC_SRC_JMP = 2'd2,
    PC_SRC_RA  = 2'd3
  } pc_src_e;
  typedef enum logic [1:0] {
    RAS_EMPTY   = 2'd0,
    RAS_PARTIAL = 2'd1,
    RAS_FULL    = 2'd2
  } ras_state_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control-side bundle of the program-counter unit.
//   master : control unit (drives pc_en, pc_src, call, i_imm, j_imm, clear_flags)
//   slave  : pc_sequencer (drives pc, ras_top, ras_count, ras_empty, ras_full,
//            ras_overflow, ras_underflow)
interface pc_sequencer_if #(
  parameter int ADDR_W    = 32,
  parameter int JIMM_W    = 26,
  parameter int RAS_DEPTH = 8
);
  import pc_pkg::*;
  logic                         pc_en;
  pc_src_e                      pc_src;
  logic                         call;
  logic [ADDR_W-1:0]            i_imm;
  logic [JIMM_W-1:0]            j_imm;
  logic                         clear_flags;
  logic [ADDR_W-1:0]            pc;
  logic [ADDR_W-1:0]            ras_top;
  logic [$clog2(RAS_DEPTH):0]   ras_count;
  logic                         ras_empty;
  logic                         ras_full;
  logic                         ras_overflow;
  logic                         ras_underflow;
  modport master (
    output pc_en, pc_src, call, i_imm, j_imm, clear_flags,
    input  pc, ras_top, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );
  modport slave (
    input  pc_en, pc_src, call, i_imm, j_imm, clear_flags,
    output pc, ras_top, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/ras_stack.sv
// ras_stack: circular LIFO of return addresses; a push while full overwrites the oldest entry.
//   clock, reset_n      : clock, asynchronous active-low reset
//   push, push_data     : store push_data on top (push wins if both are set)
//   pop                 : drop the top entry (no effect when empty)
//   top, count          : top entry (0 when empty), valid entries
//   full, empty         : occupancy
//   overflow, underflow : single-cycle fault pulses (push while full / pop while empty)
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);
  import pc_pkg::*;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    cnt;
  ras_state_e       state, state_nx;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= RAS_EMPTY;
    else          state <= state_nx;
  always_comb begin
    state_nx  = state;
    overflow  = push && state == RAS_FULL;
    underflow = pop && !push && state == RAS_EMPTY;
    case (state)
      RAS_EMPTY:   state_nx = push ? RAS_PARTIAL : RAS_EMPTY;
      RAS_PARTIAL: state_nx = push ? (cnt == CW'(DEPTH - 1) ? RAS_FULL : RAS_PARTIAL)
                            : pop ? (cnt == CW'(1) ? RAS_EMPTY : RAS_PARTIAL) : RAS_PARTIAL;
      RAS_FULL:    state_nx = !push && pop ? RAS_PARTIAL : RAS_FULL;
      default:     state_nx = RAS_EMPTY;
    endcase
  end
  // ptr names the next free slot; once full it aliases the oldest entry, so a push overwrites it.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PW'(1);
      cnt      <= full ? cnt : cnt + CW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - CW'(1);
    end
  assign empty = state == RAS_EMPTY;
  assign full  = state == RAS_FULL;
  assign count = cnt;
  assign top   = empty ? '0 : mem[ptr - PW'(1)];
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with next-PC mux, hardware return-address stack and sticky stack faults.
//   clock, reset_n : clock, asynchronous active-low reset (pc loads RESET_PC)
//   bus (slave)    : pc_en stall, pc_src/call select, i_imm/j_imm immediates, clear_flags;
//                    pc, ras_top/count/empty/full, sticky ras_overflow/ras_underflow
module pc_sequencer #(
  parameter int              ADDR_W    = 32,
  parameter int              JIMM_W    = 26,
  parameter int              PC_INC    = 1,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic        clock,
  input  logic        reset_n,
  pc_sequencer_if.slave bus
);
  import pc_pkg::*;
  logic [ADDR_W-1:0]            pc_q, pc_nx, seq_pc, top;
  logic [$clog2(RAS_DEPTH):0]   count;
  logic                         push, pop, full, empty, ovf_p, udf_p, ovf_q, udf_q;
  assign seq_pc = pc_q + ADDR_W'(PC_INC);
  assign push   = bus.pc_en && bus.pc_src == PC_SRC_JMP && bus.call;
  assign pop    = bus.pc_en && bus.pc_src == PC_SRC_RA;
  // A return on an empty stack falls through to the sequential address.
  assign pc_nx = bus.pc_src == PC_SRC_BTA ? pc_q + bus.i_imm
               : bus.pc_src == PC_SRC_JMP ? {pc_q[ADDR_W-1:JIMM_W], bus.j_imm}
               : bus.pc_src == PC_SRC_RA && !empty ? top
               : seq_pc;
  ras_stack #(.WIDTH(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (seq_pc),
    .top       (top),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (ovf_p),
    .underflow (udf_p)
  );
  // Fault pulses are already qualified by pc_en; a new fault beats a same-cycle clear.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.pc_en) pc_q <= pc_nx;
      ovf_q <= ovf_p || (ovf_q && !bus.clear_flags);
      udf_q <= udf_p || (udf_q && !bus.clear_flags);
    end
  assign bus.pc            = pc_q;
  assign bus.ras_top       = top;
  assign bus.ras_count     = count;
  assign bus.ras_empty     = empty;
  assign bus.ras_full      = full;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = udf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
  import pc_pkg::*;
  localparam int AW = 32;
  localparam int JW = 26;
  localparam int D  = 8;
  localparam logic [AW-1:0] JMASK = (AW'(1) << JW) - AW'(1);
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  pc_sequencer_if #(.ADDR_W(AW), .JIMM_W(JW), .RAS_DEPTH(D)) bus ();
  pc_sequencer_if #(.ADDR_W(AW), .JIMM_W(JW), .RAS_DEPTH(D)) bus2 ();
  pc_sequencer #(.ADDR_W(AW), .JIMM_W(JW), .PC_INC(1), .RAS_DEPTH(D), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));
  pc_sequencer #(.ADDR_W(AW), .JIMM_W(JW), .PC_INC(1), .RAS_DEPTH(D), .RESET_PC(32'h100)) dut_rv (
    .clock(clock), .reset_n(reset_n), .bus(bus2));
  int total = 0;
  int bad = 0;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_q[$];
  bit m_ovf, m_udf;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_pc = '0;
    m_q.delete();
    m_ovf = 0;
    m_udf = 0;
  endtask
  task automatic model_edge(input bit en, input pc_src_e src, input bit cl,
                            input logic [AW-1:0] ii, input logic [JW-1:0] jj, input bit clr);
    bit no = 0, nu = 0;
    if (en) begin
      if (src == PC_SRC_DFT) m_pc = m_pc + 1;
      else if (src == PC_SRC_BTA) m_pc = m_pc + ii;
      else if (src == PC_SRC_JMP) begin
        if (cl) begin
          if (m_q.size() == D) begin
            void'(m_q.pop_front());
            no = 1;
          end
          m_q.push_back(m_pc + 1);
        end
        m_pc = (m_pc & ~JMASK) | AW'(jj);
      end else if (m_q.size() == 0) begin
        m_pc = m_pc + 1;
        nu = 1;
      end else m_pc = m_q.pop_back();
    end
    m_ovf = no || (m_ovf && !clr);
    m_udf = nu || (m_udf && !clr);
  endtask
  task automatic check_all(input string tag);
    logic [AW-1:0] t;
    t = m_q.size() != 0 ? m_q[m_q.size()-1] : '0;
    check({tag, ".pc"}, bus.pc, m_pc);
    check({tag, ".top"}, bus.ras_top, t);
    check({tag, ".count"}, bus.ras_count, m_q.size());
    check({tag, ".empty"}, bus.ras_empty, m_q.size() == 0);
    check({tag, ".full"}, bus.ras_full, m_q.size() == D);
    check({tag, ".ovf"}, bus.ras_overflow, m_ovf);
    check({tag, ".udf"}, bus.ras_underflow, m_udf);
  endtask
  task automatic step(input bit en, input pc_src_e src, input bit cl,
                      input logic [AW-1:0] ii, input logic [JW-1:0] jj, input bit clr,
                      input string tag);
    bus.pc_en = en;
    bus.pc_src = src;
    bus.call = cl;
    bus.i_imm = ii;
    bus.j_imm = jj;
    bus.clear_flags = clr;
    @(posedge clock);
    model_edge(en, src, cl, ii, jj, clr);
    #1;
    check_all(tag);
  endtask
  task automatic set_pc(input logic [AW-1:0] target);
    step(1, PC_SRC_BTA, 0, target - m_pc, '0, 0, "setpc");
  endtask
  initial begin
    bus2.pc_en = 1; bus2.pc_src = PC_SRC_DFT; bus2.call = 0;
    bus2.i_imm = '0; bus2.j_imm = '0; bus2.clear_flags = 0;
    bus.pc_en = 0; bus.pc_src = PC_SRC_DFT; bus.call = 0;
    bus.i_imm = '0; bus.j_imm = '0; bus.clear_flags = 0;
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    check("rv.reset", bus2.pc, 32'h100);
    reset_n = 1;
    for (int i = 0; i < 3; i++) step(1, PC_SRC_DFT, 0, '0, '0, 0, "dft");
    check("dft3", bus.pc, 3);
    check("rv.dft3", bus2.pc, 32'h103);
    set_pc(10);
    step(1, PC_SRC_BTA, 0, 32'hFFFF_FFFD, '0, 0, "bta");
    check("bta_neg", bus.pc, 7);
    set_pc(32'hFFFF_FFFF);
    step(1, PC_SRC_DFT, 0, '0, '0, 0, "wrap");
    check("wrap0", bus.pc, 0);
    set_pc(32'h0400_0005);
    step(1, PC_SRC_JMP, 1, '0, 26'h20, 0, "call");
    check("call.pc", bus.pc, 32'h0400_0020);
    check("call.top", bus.ras_top, 32'h0400_0006);
    check("call.cnt", bus.ras_count, 1);
    step(1, PC_SRC_RA, 0, '0, '0, 0, "ret");
    check("ret.pc", bus.pc, 32'h0400_0006);
    check("ret.empty", bus.ras_empty, 1);
    for (int i = 0; i < 9; i++) begin
      set_pc(32'h1000 + 32'h100 * i);
      step(1, PC_SRC_JMP, 1, '0, 26'h3000 + 26'(i), 0, "call9");
    end
    check("ovf.cnt", bus.ras_count, 8);
    check("ovf.flag", bus.ras_overflow, 1);
    set_pc(32'h2000);
    for (int k = 0; k < 8; k++) begin
      step(1, PC_SRC_RA, 0, '0, '0, 0, "ret8");
      check("ret8.lifo", bus.pc, 32'h1001 + 32'h100 * (8 - k));
    end
    step(1, PC_SRC_RA, 0, '0, '0, 0, "ret9");
    check("ret9.pc", bus.pc, 32'h1102);
    check("ret9.udf", bus.ras_underflow, 1);
    for (int i = 0; i < 4; i++) step(0, PC_SRC_RA, 1, 32'h55, 26'h77, 0, "stall");
    check("stall.pc", bus.pc, 32'h1102);
    step(0, PC_SRC_JMP, 1, '0, 26'h5, 1, "stall_clr");
    check("clr.ovf", bus.ras_overflow, 0);
    check("clr.udf", bus.ras_underflow, 0);
    step(1, PC_SRC_RA, 0, '0, '0, 1, "udf_vs_clr");
    for (int i = 0; i < 3; i++) step(1, PC_SRC_JMP, 1, '0, 26'h40 + 26'(i), 0, "call3");
    check("pre_rst.cnt", bus.ras_count, 3);
    #2;
    reset_n = 0;
    #1;
    check("arst.pc", bus.pc, 0);
    check("arst.cnt", bus.ras_count, 0);
    check("arst.udf", bus.ras_underflow, 0);
    check("arst.top", bus.ras_top, 0);
    m_reset();
    @(posedge clock);
    #1;
    check_all("arst_hold");
    reset_n = 1;
    for (int n = 0; n < 600; n++) begin
      int r;
      pc_src_e s;
      logic [AW-1:0] ii;
      r = $urandom_range(0, 9);
      s = r < 4 ? PC_SRC_JMP : r < 7 ? PC_SRC_RA : r == 7 ? PC_SRC_BTA : PC_SRC_DFT;
      ii = $urandom_range(0, 1) != 0 ? AW'($urandom) : AW'($urandom_range(0, 64)) - AW'(32);
      step($urandom_range(0, 7) != 0, s, r != 3, ii, JW'($urandom), $urandom_range(0, 15) == 0, "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
